// File: rtl/rdata_handler_pkg.sv
// rdata_handler_pkg
//   Shared types for the read-side streamer: address/data widths, the row
//   type fed to the systolic array, and the streamer FSM state encoding.
package rdata_handler_pkg;

  localparam int SYS_ARRAY_SIZE = 4;
  localparam int ADDR_W         = 8;
  localparam int DATA_W         = 16;
  localparam int ROW_BITS       = SYS_ARRAY_SIZE * DATA_W;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;
  typedef data_t [SYS_ARRAY_SIZE-1:0] row_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } rd_state_e;

endpackage

// File: rtl/rdata_handler_if.sv
// rdata_handler_if
//   Bundles the streamer's command inputs, the two RAM read ports and the
//   skewed lane outputs toward the systolic array.
//   slave  : the rdata_handler side (drives RAM requests and lanes)
//   master : the environment side (issues commands, returns RAM data)
//
// Handshake: there is no backpressure anywhere. start_i is a single-cycle
// command sampled only while the streamer is idle; RAM data is valid exactly
// one cycle after the matching en_*_o; a lane value is meaningful only while
// its lane_valid_o bit is high and reads as zero otherwise.
interface rdata_handler_if
  import rdata_handler_pkg::*;
#(
  parameter int N     = SYS_ARRAY_SIZE,
  parameter int LEN_W = 8
) ();

  logic                  start_i;
  addr_t                 addr_a_i;
  addr_t                 addr_b_i;
  logic [LEN_W-1:0]      len_i;
  logic                  en_a_o;
  addr_t                 addr_a_o;
  logic [N*DATA_W-1:0]   rdata_a_i;
  logic                  en_b_o;
  addr_t                 addr_b_o;
  logic [N*DATA_W-1:0]   rdata_b_i;
  data_t [N-1:0]         a_o;
  data_t [N-1:0]         b_o;
  logic [N-1:0]          lane_valid_o;
  logic                  busy_o;
  logic                  done_o;
  rd_state_e             state_o;   // debug view of the streamer FSM

  modport slave (
    input  start_i, addr_a_i, addr_b_i, len_i, rdata_a_i, rdata_b_i,
    output en_a_o, addr_a_o, en_b_o, addr_b_o, a_o, b_o, lane_valid_o,
           busy_o, done_o, state_o
  );

  modport master (
    output start_i, addr_a_i, addr_b_i, len_i, rdata_a_i, rdata_b_i,
    input  en_a_o, addr_a_o, en_b_o, addr_b_o, a_o, b_o, lane_valid_o,
           busy_o, done_o, state_o
  );

endinterface

// File: rtl/rdata_handler_skew_buffer.sv
// rdata_handler_skew_buffer
//   Triangular shift register: lane i of an incoming row is delayed by i
//   cycles so rows enter the systolic array on a diagonal wavefront.
//   clk_i, rst_i : clock, asynchronous active-low reset
//   row_i/valid_i: one row and its valid bit
//   row_o/valid_o: skewed lanes and the matching per-lane valid vector
module rdata_handler_skew_buffer
  import rdata_handler_pkg::*;
#(
  parameter int N = SYS_ARRAY_SIZE
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  data_t [N-1:0] row_i,
  input  logic          valid_i,
  output data_t [N-1:0] row_o,
  output logic  [N-1:0] valid_o
);

  // Lane 0 has no delay; invalid data is forced to zero so the array sees
  // zero padding outside the wavefront.
  assign row_o[0]   = valid_i ? row_i[0] : '0;
  assign valid_o[0] = valid_i;

  for (genvar i = 1; i < N; i++) begin : g_lane
    data_t [i-1:0] d_q;
    logic  [i-1:0] v_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
        d_q <= '0;
        v_q <= '0;
      end else begin
        d_q[0] <= valid_i ? row_i[i] : '0;
        v_q[0] <= valid_i;
        for (int s = 1; s < i; s++) begin
          d_q[s] <= d_q[s-1];
          v_q[s] <= v_q[s-1];
        end
      end
    end

    assign row_o[i]   = d_q[i-1];
    assign valid_o[i] = v_q[i-1];
  end

endmodule

// File: rtl/rdata_handler.sv
// rdata_handler
//   On start, reads K consecutive rows of A and B from the dual-port RAM
//   (one row per cycle) and presents them diagonally skewed to the left (A)
//   and top (B) edges of the systolic array.
//   clk_i : clock
//   rst_i : asynchronous active-low reset
//   bus   : command, RAM read ports and lane outputs (slave side)
module rdata_handler
  import rdata_handler_pkg::*;
#(
  parameter int N     = SYS_ARRAY_SIZE,
  parameter int LEN_W = 8
) (
  input  logic            clk_i,
  input  logic            rst_i,
  rdata_handler_if.slave  bus
);

  rd_state_e        state_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] cnt_q;      // row index in READ, drain cycle in DRAIN
  logic             en_q;
  addr_t            addr_a_q;
  addr_t            addr_b_q;
  logic             busy_q;
  logic             done_q;
  logic             rd_vld_q;   // RAM data of the previous request is on rdata_*

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= IDLE;
      len_q    <= '0;
      cnt_q    <= '0;
      en_q     <= 1'b0;
      addr_a_q <= '0;
      addr_b_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      rd_vld_q <= 1'b0;
    end else begin
      done_q   <= 1'b0;
      rd_vld_q <= en_q;
      case (state_q)
        IDLE: begin
          if (bus.start_i) begin
            if (bus.len_i == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q  <= READ;
              busy_q   <= 1'b1;
              en_q     <= 1'b1;
              addr_a_q <= bus.addr_a_i;
              addr_b_q <= bus.addr_b_i;
              len_q    <= bus.len_i;
              cnt_q    <= '0;
            end
          end
        end
        READ: begin
          if (cnt_q == len_q - LEN_W'(1)) begin
            // Addresses keep their last value through DRAIN.
            state_q <= DRAIN;
            en_q    <= 1'b0;
            cnt_q   <= '0;
          end else begin
            cnt_q    <= cnt_q + LEN_W'(1);
            addr_a_q <= addr_a_q + addr_t'(1);
            addr_b_q <= addr_b_q + addr_t'(1);
          end
        end
        DRAIN: begin
          // N cycles: one for the RAM latency of the last row plus N-1 for
          // it to walk through the deepest skew lane.
          if (cnt_q == LEN_W'(N - 1)) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + LEN_W'(1);
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  data_t [N-1:0] row_a;
  data_t [N-1:0] row_b;
  logic  [N-1:0] vld_a;
  logic  [N-1:0] vld_b;

  assign row_a = bus.rdata_a_i;
  assign row_b = bus.rdata_b_i;

  rdata_handler_skew_buffer #(.N(N)) u_skew_a (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .row_i   (row_a),
    .valid_i (rd_vld_q),
    .row_o   (bus.a_o),
    .valid_o (vld_a)
  );

  rdata_handler_skew_buffer #(.N(N)) u_skew_b (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .row_i   (row_b),
    .valid_i (rd_vld_q),
    .row_o   (bus.b_o),
    .valid_o (vld_b)
  );

  // Both skew chains carry the same valid stream; combining them keeps the
  // lane valid honest for A and B alike.
  assign bus.lane_valid_o = vld_a & vld_b;
  assign bus.en_a_o       = en_q;
  assign bus.en_b_o       = en_q;
  assign bus.addr_a_o     = addr_a_q;
  assign bus.addr_b_o     = addr_b_q;
  assign bus.busy_o       = busy_q;
  assign bus.done_o       = done_q;
  assign bus.state_o      = state_q;

endmodule

// File: tb/tb_rdata_handler.sv
// tb_rdata_handler
//   Self-checking bench for rdata_handler with a behavioural RAM, a
//   transaction-level reference model feeding expected queues, and a
//   negedge monitor that pops and compares.
module tb_rdata_handler;
  import rdata_handler_pkg::*;

  localparam int N = 4;

  logic clk;
  logic rst_n;
  int   cyc = 0;

  rdata_handler_if #(.N(N), .LEN_W(8)) bus ();

  rdata_handler #(.N(N), .LEN_W(8)) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- RAM model ----------------
  logic [N*DATA_W-1:0] mem_a [256];
  logic [N*DATA_W-1:0] mem_b [256];

  initial begin
    for (int r = 0; r < 256; r++) begin
      for (int i = 0; i < N; i++) begin
        mem_a[r][i*DATA_W +: DATA_W] = 16'(16 * r + i);
        mem_b[r][i*DATA_W +: DATA_W] = 16'(256 + 16 * r + i);
      end
    end
  end

  always @(posedge clk) begin
    if (bus.en_a_o) bus.rdata_a_i <= mem_a[bus.addr_a_o];
    if (bus.en_b_o) bus.rdata_b_i <= mem_b[bus.addr_b_o];
  end

  // ---------------- scoreboard state ----------------
  int          n_cmp  = 0;
  int          n_fail = 0;
  logic [63:0] lane_q [N][$];   // {cycle, a, b}
  logic [63:0] addr_q [$];      // {cycle, 14'b0, en_a, en_b, addr_a, addr_b}
  logic [63:0] done_q [$];      // cycle of the done pulse
  int          busy_lo   = 1;
  int          busy_hi   = 0;
  int          next_free = 0;   // first cycle the streamer is idle again

  task automatic check_eq(input string name, input logic [63:0] act,
                          input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  // ---------------- driver + reference model ----------------
  task automatic do_start(input logic [7:0] ba, input logic [7:0] bb,
                          input logic [7:0] len);
    int t;
    int kk;
    logic [7:0] ra;
    logic [7:0] rb;
    @(negedge clk);
    t = cyc;
    bus.start_i  = 1'b1;
    bus.addr_a_i = ba;
    bus.addr_b_i = bb;
    bus.len_i    = len;
    if (t >= next_free) begin
      kk = int'(len);
      if (kk == 0) begin
        done_q.push_back(64'(t + 1));
        busy_lo   = t + 1;
        busy_hi   = t;
        next_free = t + 2;
      end else begin
        for (int k = 0; k < kk; k++) begin
          ra = 8'(int'(ba) + k);
          rb = 8'(int'(bb) + k);
          addr_q.push_back({32'(t + 1 + k), 14'b0, 2'b11, ra, rb});
          for (int i = 0; i < N; i++)
            lane_q[i].push_back({32'(t + 2 + k + i),
                                 16'(16 * int'(ra) + i),
                                 16'(256 + 16 * int'(rb) + i)});
        end
        done_q.push_back(64'(t + kk + N + 1));
        busy_lo   = t + 1;
        busy_hi   = t + kk + N;
        next_free = t + kk + N + 2;
      end
    end
    @(negedge clk);
    bus.start_i = 1'b0;
  endtask

  task automatic wait_free();
    int guard;
    guard = 0;
    while (cyc < next_free - 1 && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [63:0] e;
    if (rst_n) begin
      for (int i = 0; i < N; i++) begin
        if (bus.lane_valid_o[i]) begin
          if (lane_q[i].size() == 0) begin
            check_eq($sformatf("lane%0d_extra", i), 64'(bus.lane_valid_o[i]), 64'd0);
          end else begin
            e = lane_q[i].pop_front();
            check_eq($sformatf("lane%0d_data", i),
                     {32'(cyc), bus.a_o[i], bus.b_o[i]}, e);
          end
        end else begin
          check_eq($sformatf("lane%0d_pad", i), {32'd0, bus.a_o[i], bus.b_o[i]}, 64'd0);
          if (lane_q[i].size() > 0 && int'(lane_q[i][0][63:32]) <= cyc) begin
            check_eq($sformatf("lane%0d_missing", i), 64'(bus.lane_valid_o[i]), 64'd1);
            void'(lane_q[i].pop_front());
          end
        end
      end

      if (bus.en_a_o || bus.en_b_o) begin
        if (addr_q.size() == 0) begin
          check_eq("ram_extra", {62'd0, bus.en_a_o, bus.en_b_o}, 64'd0);
        end else begin
          e = addr_q.pop_front();
          check_eq("ram_rd", {32'(cyc), 14'b0, bus.en_a_o, bus.en_b_o,
                              bus.addr_a_o, bus.addr_b_o}, e);
        end
      end else if (addr_q.size() > 0 && int'(addr_q[0][63:32]) <= cyc) begin
        check_eq("ram_missing", 64'(bus.en_a_o), 64'd1);
        void'(addr_q.pop_front());
      end

      if (bus.done_o) begin
        if (done_q.size() == 0) begin
          check_eq("done_extra", 64'(bus.done_o), 64'd0);
        end else begin
          e = done_q.pop_front();
          check_eq("done_cycle", 64'(cyc), e);
        end
      end else if (done_q.size() > 0 && int'(done_q[0]) <= cyc) begin
        check_eq("done_missing", 64'(bus.done_o), 64'd1);
        void'(done_q.pop_front());
      end

      check_eq("busy", 64'(bus.busy_o), 64'(cyc >= busy_lo && cyc <= busy_hi));
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    repeat (20000) @(posedge clk);
    n_fail++;
    $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] ra;
    logic [7:0] rb;
    logic [7:0] rl;
    rst_n         = 1'b0;
    bus.start_i   = 1'b0;
    bus.addr_a_i  = '0;
    bus.addr_b_i  = '0;
    bus.len_i     = '0;
    bus.rdata_a_i = '0;
    bus.rdata_b_i = '0;

    repeat (3) @(negedge clk);
    check_eq("rst_en_addr", {46'd0, bus.en_a_o, bus.en_b_o, bus.addr_a_o, bus.addr_b_o}, 64'd0);
    check_eq("rst_a", 64'(bus.a_o), 64'd0);
    check_eq("rst_b", 64'(bus.b_o), 64'd0);
    check_eq("rst_flags", {59'd0, bus.lane_valid_o, bus.busy_o}, 64'd0);
    check_eq("rst_done", 64'(bus.done_o), 64'd0);
    check_eq("rst_state", 64'(bus.state_o), 64'(IDLE));
    #2 rst_n = 1'b1;

    // Directed cases
    do_start(8'd0, 8'd8, 8'd3);      wait_free();
    do_start(8'd40, 8'd50, 8'd1);    wait_free();
    do_start(8'd5, 8'd6, 8'd0);      wait_free();
    do_start(8'hff, 8'h10, 8'd2);    wait_free();
    // second start lands in READ and must be ignored
    do_start(8'd1, 8'd2, 8'd6);
    do_start(8'd100, 8'd120, 8'd4);
    wait_free();
    // start right after DONE
    do_start(8'd7, 8'd9, 8'd2);
    wait_free();

    // Randomised traffic, including starts that land while busy
    for (int it = 0; it < 40; it++) begin
      repeat ($urandom_range(0, 8)) @(negedge clk);
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rl = 8'($urandom_range(0, 6));
      do_start(ra, rb, rl);
    end
    wait_free();

    // Asynchronous reset in the middle of a len=5 transfer
    do_start(8'd20, 8'd30, 8'd5);    // ends at negedge t+1
    repeat (2) @(negedge clk);       // negedge of t+3
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_en_addr", {46'd0, bus.en_a_o, bus.en_b_o, bus.addr_a_o, bus.addr_b_o}, 64'd0);
    check_eq("arst_lanes", {32'd0, 28'd0, bus.lane_valid_o}, 64'd0);
    check_eq("arst_a", 64'(bus.a_o), 64'd0);
    check_eq("arst_b", 64'(bus.b_o), 64'd0);
    check_eq("arst_busy_done", {62'd0, bus.busy_o, bus.done_o}, 64'd0);
    for (int i = 0; i < N; i++) lane_q[i].delete();
    addr_q.delete();
    done_q.delete();
    busy_lo   = 1;
    busy_hi   = 0;
    next_free = 0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    do_start(8'd60, 8'd70, 8'd3);
    wait_free();

    repeat (N + 4) @(negedge clk);
    for (int i = 0; i < N; i++)
      check_eq($sformatf("lane%0d_left", i), 64'(lane_q[i].size()), 64'd0);
    check_eq("ram_left", 64'(addr_q.size()), 64'd0);
    check_eq("done_left", 64'(done_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
